// File: rtl/credit_return_queue.sv
// credit_return_queue: receive queue at the output of a fixed-latency,
// no-backpressure pipeline. Issue credits are granted only while every
// launched operation is guaranteed a buffer slot on return. Results land in
// a circular buffer and drain through a show-ahead valid/ready interface.
module credit_return_queue #(
  parameter  int DATA_SIZE = 256,
  parameter  int DEPTH     = 8,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic                 ret_valid,
  input  logic [DATA_SIZE-1:0] ret_data,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data,
  input  logic                 out_ready,
  output logic [CW-1:0]        count,
  output logic [CW-1:0]        inflight,
  output logic                 err_overflow,
  output logic                 err_underflow
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;

  logic fire;
  logic pop;
  logic push;
  logic full;
  logic ret_dec;
  logic ret_drop;
  logic ret_orphan;
  logic [CW:0] committed;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Slots already promised = stored entries plus operations still in the
  // pipeline; a credit exists while that total is below DEPTH. Only
  // registered state feeds issue_ready, so there is no input-to-output path.
  assign committed   = {1'b0, count} + {1'b0, inflight};
  assign issue_ready = committed < {1'b0, DEPTH_C};

  assign fire       = issue_valid & issue_ready;
  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  assign full       = (count == DEPTH_C);
  // A pop on the same edge frees the slot the incoming result needs.
  assign push       = ret_valid & (~full | pop);
  assign ret_drop   = ret_valid & full & ~pop;
  assign ret_orphan = ret_valid & (inflight == '0);
  // Inflight saturates at zero: an unexpected return never wraps it.
  assign ret_dec    = ret_valid & ~ret_orphan;

  // Show-ahead head word straight from storage; no bypass from ret_data.
  assign out_data = mem[rd_ptr];

  // Result storage write port.
  // NOTE: the buffer array has no reset; every slot is written before it can
  // be read (out_valid gates it), so clearing it would only cost hardware.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ret_data;
  end

  // Control state: pointers, occupancy, inflight credits and sticky errors.
  // NOTE: all state here uses non-blocking assignments so every term of the
  // next-state arithmetic sees the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      inflight      <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case ({fire, ret_dec})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase

      if (ret_drop)   err_overflow  <= 1'b1;
      if (ret_orphan) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_credit_return_queue.sv
// Directed bench for credit_return_queue. A DEPTH=4 instance sits behind a
// behavioural fixed-latency pipeline; a DEPTH=8 instance is driven directly
// to reach a mixed stored/in-flight state before a mid-operation reset.
module tb_credit_return_queue;

  localparam int DW  = 32;
  localparam int DW8 = 16;

  logic clk = 1'b0;
  logic rst;

  // DEPTH=4 instance signals
  logic          issue_valid, issue_ready;
  logic          ret_valid;
  logic [DW-1:0] ret_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [2:0]    count, inflight;
  logic          err_overflow, err_underflow;

  // DEPTH=8 instance signals
  logic           i8_valid, i8_ready;
  logic           r8_valid;
  logic [DW8-1:0] r8_data;
  logic           o8_valid;
  logic [DW8-1:0] o8_data;
  logic           o8_ready;
  logic [3:0]     c8_count, c8_inflight;
  logic           e8_over, e8_under;

  credit_return_queue #(.DATA_SIZE(DW), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .inflight(inflight),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  credit_return_queue #(.DATA_SIZE(DW8), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .issue_valid(i8_valid), .issue_ready(i8_ready),
    .ret_valid(r8_valid), .ret_data(r8_data),
    .out_valid(o8_valid), .out_data(o8_data), .out_ready(o8_ready),
    .count(c8_count), .inflight(c8_inflight),
    .err_overflow(e8_over), .err_underflow(e8_under)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Pipeline model: hist_v[k] holds a launch from k+1 cycles ago.
  int            lat;
  bit            hist_v [8];
  logic [DW-1:0] hist_d [8];
  logic [DW-1:0] issue_data;
  bit            force_ret;
  logic [DW-1:0] force_data;
  int            fires;
  int            pops;
  bit            pop_flag;
  logic [DW-1:0] pop_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle on the DEPTH=4 instance, entered and left 1 time unit
  // after a rising edge.
  task automatic cycle();
    bit fire_now;
    if (force_ret) begin
      ret_valid = 1'b1;
      ret_data  = force_data;
    end else begin
      ret_valid = hist_v[lat-1];
      ret_data  = hist_d[lat-1];
    end
    #1;
    fire_now = issue_valid & issue_ready;
    if (fire_now) fires++;
    pop_flag = out_valid & out_ready;
    pop_data = out_data;
    if (pop_flag) pops++;
    @(posedge clk);
    for (int k = 7; k > 0; k--) begin
      hist_v[k] = hist_v[k-1];
      hist_d[k] = hist_d[k-1];
    end
    hist_v[0] = fire_now;
    hist_d[0] = issue_data;
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    issue_valid = 1'b0;
    out_ready   = 1'b0;
    ret_valid   = 1'b0;
    ret_data    = '0;
    force_ret   = 1'b0;
    issue_data  = '0;
    for (int k = 0; k < 8; k++) begin
      hist_v[k] = 1'b0;
      hist_d[k] = '0;
    end
    fires = 0;
    pops  = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic tick8();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp1 [10] = '{0, 0, 0, 1, 2, 3, 4, 4, 4, 4};
    logic [DW-1:0] drain_exp [4] = '{32'h1, 32'h2, 32'h3, 32'hAA};
    int f0;
    int exp_val;

    i8_valid = 1'b0; r8_valid = 1'b0; r8_data = '0; o8_ready = 1'b0;
    lat = 1;
    do_reset();

    // Reset state
    check("rst_count", count, 0);
    check("rst_inflight", inflight, 0);
    check("rst_issue_ready", issue_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_errs", {err_overflow, err_underflow}, 0);

    // Latency 3, continuous issue, no drain: credits stop at DEPTH
    lat = 3;
    issue_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue_data = fires;
      cycle();
      check($sformatf("fill_count_%0d", i), count, exp1[i]);
    end
    check("fill_fires", fires, 4);
    check("fill_issue_ready", issue_ready, 0);
    check("fill_inflight", inflight, 0);
    check("fill_errs", {err_overflow, err_underflow}, 0);

    // One pop frees one credit, exactly one more launch follows
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("pop1_data", pop_data, 0);
    check("pop1_count", count, 3);
    check("pop1_issue_ready", issue_ready, 1);
    f0 = fires;
    for (int i = 0; i < 6; i++) begin
      issue_data = fires;
      cycle();
    end
    check("refill_fires", fires - f0, 1);
    check("refill_count", count, 4);
    check("refill_inflight", inflight, 0);
    check("refill_overflow", err_overflow, 0);

    // Latency 2, streaming 100 words with the consumer always ready
    do_reset();
    lat = 2;
    out_ready = 1'b1;
    exp_val = 0;
    for (int i = 0; i < 120 && pops < 100; i++) begin
      issue_valid = (fires < 100);
      issue_data  = fires;
      cycle();
      if (pop_flag) begin
        if (exp_val == 0) check("stream_first_cycle", i, 3);
        check("stream_data", pop_data, exp_val);
        exp_val++;
      end
      check("stream_count_le1", count <= 3'd1, 1);
    end
    issue_valid = 1'b0;
    check("stream_fires", fires, 100);
    check("stream_pops", pops, 100);
    check("stream_errs", {err_overflow, err_underflow}, 0);

    // Full queue: forced return with simultaneous pop, then without
    do_reset();
    lat = 1;
    issue_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue_data = fires;
      cycle();
    end
    issue_valid = 1'b0;
    check("full_fires", fires, 4);
    check("full_count", count, 4);
    force_ret  = 1'b1;
    force_data = 32'hAA;
    out_ready  = 1'b1;
    cycle();
    check("full_pop_data", pop_data, 0);
    check("full_pop_count", count, 4);
    check("full_pop_overflow", err_overflow, 0);
    force_data = 32'hBB;
    out_ready  = 1'b0;
    cycle();
    force_ret = 1'b0;
    check("ovf_flag", err_overflow, 1);
    check("ovf_count", count, 4);
    check("ovf_head_hold", out_data, 1);
    cycle();
    check("ovf_head_stable", out_data, 1);
    check("ovf_sticky", err_overflow, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("drain_%0d", i), pop_data, drain_exp[i]);
    end
    check("drain_count", count, 0);
    check("drain_out_valid", out_valid, 0);

    // Return with nothing in flight
    do_reset();
    force_ret  = 1'b1;
    force_data = 32'h55;
    cycle();
    force_ret = 1'b0;
    check("unf_flag", err_underflow, 1);
    check("unf_inflight", inflight, 0);
    check("unf_out_valid", out_valid, 1);
    check("unf_out_data", out_data, 32'h55);
    check("unf_overflow", err_overflow, 0);

    // Mid-operation reset on the DEPTH=8 instance with count=3, inflight=2
    r8_valid = 1'b1; r8_data = 16'h7;
    tick8();
    r8_valid = 1'b0;
    i8_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick8();
    i8_valid = 1'b0;
    r8_valid = 1'b1;
    for (int i = 0; i < 2; i++) tick8();
    r8_valid = 1'b0;
    check("pre_rst_count", c8_count, 3);
    check("pre_rst_inflight", c8_inflight, 2);
    check("pre_rst_underflow", e8_under, 1);
    rst = 1'b1;
    tick8();
    rst = 1'b0;
    check("post_rst_count", c8_count, 0);
    check("post_rst_inflight", c8_inflight, 0);
    check("post_rst_out_valid", o8_valid, 0);
    check("post_rst_issue_ready", i8_ready, 1);
    check("post_rst_errs", {e8_over, e8_under}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/credit_return_queue.md
Name: credit_return_queue

Overview:
- Consumer-side receive queue at the output of a fixed-latency datapath pipeline, such as an NTT stage chain built from delay lines.
- The pipeline has no backpressure, so this block enforces flow control at the producer side. It grants issue credits only when every result already launched has a guaranteed slot.
- Results land in a circular buffer and drain through a valid/ready interface, which decouples the downstream consumer from the pipeline's rigid timing.

Parameters:
- DATA_SIZE, 256, width of each result word in bits.
- DEPTH, 8, number of buffer entries. Legal range is 2..64; DEPTH need not be a power of 2.
- CW, $clog2(DEPTH+1), width of all count outputs. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- issue_valid  input  1  producer launches one operation into the pipeline this cycle.
- issue_ready  output  1  at least one credit is available; a launch is legal.
- ret_valid  input  1  a pipeline result is present this cycle.
- ret_data  input  DATA_SIZE  pipeline result word.
- out_valid  output  1  queue head is valid.
- out_data  output  DATA_SIZE  queue head word.
- out_ready  input  1  consumer accepts the head this cycle.
- count  output  CW  number of entries currently stored.
- inflight  output  CW  number of operations issued but not yet returned.
- err_overflow  output  1  sticky: a result arrived with no free slot.
- err_underflow  output  1  sticky: a result arrived while inflight was 0.

Behaviour:
- Reset, applied synchronously on any rising edge with rst=1:
  - count, inflight, rd_ptr and wr_ptr are set to 0.
  - err_overflow and err_underflow are cleared.
  - issue_ready=1 on the cycle after reset, since DEPTH is at least 1.
  - out_valid=0.
  - Buffer contents are not cleared.
  - Reset mid-operation discards all stored and in-flight items. Returns arriving after reset deasserts are counted as underflow.
- Credit rule: credits = DEPTH - count - inflight.
  - issue_ready = (credits > 0). It is computed from registered state only, with no combinational path from any input.
- issue fire = issue_valid & issue_ready.
  - issue_valid while issue_ready=0 is ignored: no state change, no error.
- pop = out_valid & out_ready.
- push = ret_valid & (count < DEPTH | pop).
  - On push, ret_data is written at wr_ptr and wr_ptr advances.
- Overflow: ret_valid with count==DEPTH and no pop.
  - The data is dropped and err_overflow is set.
  - Cannot occur if the producer honours issue_ready.
- Underflow: ret_valid with inflight==0.
  - The data is still pushed if space exists.
  - err_underflow is set and inflight stays at 0 (saturates, no wrap).
- Next-state arithmetic, with all terms evaluated on the same edge:
  - inflight_next = inflight + fire - (ret_valid & inflight != 0).
  - count_next = count + push - pop.
  - Simultaneous fire, return and pop are all honoured in one cycle.
- Pointer advance:
  - wr_ptr and rd_ptr increment modulo DEPTH; they wrap from DEPTH-1 to 0 explicitly.
  - Full/empty is determined by count, never by pointer equality.
- Output timing:
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr], show-ahead and combinational from registered state.
  - A result pushed into an empty queue appears on out_valid/out_data the cycle after ret_valid (1-cycle queue latency).
  - There is no bypass from ret_data to out_data.
  - Total issue-to-out_valid latency = pipeline latency + 1.
- Output stability: out_data and out_valid must hold stable while out_valid=1 and out_ready=0.
- Throughput:
  - With out_ready held at 1 and at least 1 credit free, one issue per cycle is sustained.
  - At steady state, count + inflight never exceeds DEPTH.
- Error flags stay set until reset.

Test Plan:
- DEPTH=4, pipeline latency 3, issue_valid=1 continuously, out_ready=0:
  - Exactly 4 fires occur, then issue_ready=0.
  - count reaches 4 three cycles after the last fire.
  - No error flags are set.
- Continuing from the previous state, raise out_ready for 1 cycle:
  - count goes 4→3.
  - issue_ready=1 the next cycle; one further fire occurs.
  - Its result is accepted without overflow.
- Latency 2, out_ready=1, 100 back-to-back issues carrying data values 0..99:
  - out_data emits 0..99 in order, one per cycle, after a 3-cycle initial delay.
  - count stays ≤1 and rd_ptr wraps correctly.
- Full queue with count=4, ret_valid=1 (forced protocol violation) and out_ready=1 in the same cycle:
  - The word is accepted, count stays 4 and err_overflow stays 0.
  - Repeating with out_ready=0 sets err_overflow=1 and count stays 4.
- ret_valid=1 while inflight=0:
  - err_underflow=1, inflight stays 0, and the word appears on out_data.
- rst=1 for one cycle with count=3 and inflight=2:
  - Next cycle: count=0, inflight=0, out_valid=0, issue_ready=1, both error flags 0.
